cpu_reg_initiator: RTL

CPU-side bus master for the host controller register file. Accepts queued register read/write commands from a command port and issues them one at a time on the req/wr_valid/addrs/wr_data register bus. Waits for acknowledge, captures rd_data, and returns one response per command, flagging a timeout or illegal address as an error. It sits between the CPU model / DMA command source and the register communication block.

---
 rtl/cpu_reg_initiator.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_reg_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_reg_initiator
//  Description : CPU-side bus master for the host controller register file.
//                Queues register read/write commands and issues them one at a
//                time on the req/wr_valid/addrs/wr_data bus. It waits for
//                acknowledge, captures rd_data, and returns exactly one
//                response per command, in order. A timeout is reported as an
//                error, and so is an illegal address when checking is enabled.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH     : command queue depth (power of two, >= 2)
//    TIMEOUT_CYCLES : max cycles req stays high without acknowledge (>= 2)
//  Build option
//    CPU_REG_ADDR_CHECK_EN : when defined, only the register map addresses
//                            are forwarded to the bus. Other addresses get an
//                            immediate error response with no bus cycle.
//  Ports
//    clk, rst_n        : clock (rising edge), asynchronous active-low reset
//    cmd_valid/ready   : command handshake (ready = queue not full)
//    cmd_write/addr/wdata : command payload
//    rsp_valid         : one-cycle response pulse (no back-pressure)
//    rsp_rdata/error   : response payload, valid with rsp_valid
//    busy              : FSM active or queue non-empty
//    req/wr_valid/addrs/wr_data : register bus request side
//    rd_data/acknowledge        : register bus completion side
// ============================================================================
module cpu_reg_initiator #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        req,
    output logic        wr_valid,
    output logic [11:0] addrs,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        acknowledge
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX  = {c_TO_W{1'b1}};

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    // ------------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------------
    logic [11:0]        r_fifo_addr  [FIFO_DEPTH];
    logic               r_fifo_write [FIFO_DEPTH];
    logic [31:0]        r_fifo_wdata [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_cmd_ready;

    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [11:0]        w_head_addr;
    logic               w_head_write;
    logic [31:0]        w_head_wdata;
    logic               w_head_legal;

    // FSM and command registers
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [11:0]        r_cmd_addr;
    logic               r_cmd_write;
    logic [31:0]        r_cmd_wdata;
    logic [11:0]        w_cmd_addr_nxt;
    logic               w_cmd_write_nxt;
    logic [31:0]        w_cmd_wdata_nxt;
    logic               w_rsp_err_nxt;
    logic [31:0]        w_rsp_rdata_nxt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               w_timeout;

    // Registered outputs and their next values
    logic               r_req;
    logic               r_wr_valid;
    logic [11:0]        r_addrs;
    logic [31:0]        r_wr_data;
    logic               r_rsp_valid;
    logic               r_rsp_error;
    logic [31:0]        r_rsp_rdata;
    logic               r_busy;
    logic               w_req_nxt;
    logic               w_wr_valid_nxt;
    logic [11:0]        w_addrs_nxt;
    logic [31:0]        w_wr_data_nxt;
    logic               w_rsp_valid_nxt;
    logic               w_rsp_error_nxt;
    logic [31:0]        w_rsp_rdata_nxt_o;
    logic               w_busy_nxt;

    // cmd_ready is a register, so a pop in the same cycle cannot open the
    // queue to a push while it is full.
    assign w_push      = cmd_valid && r_cmd_ready;
    assign w_pop       = (r_state == c_ST_IDLE) && (r_count != '0);
    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_write = r_fifo_write[r_rd_ptr];
    assign w_head_wdata = r_fifo_wdata[r_rd_ptr];

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= cmd_addr;
            r_fifo_write[r_wr_ptr] <= cmd_write;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != c_FULL);
        end
    end

    // ------------------------------------------------------------------------
    // Address legality
    // ------------------------------------------------------------------------
`ifdef CPU_REG_ADDR_CHECK_EN
    function automatic logic f_addr_legal(input logic [11:0] addr, input logic wr);
        logic ok;
        case (addr)
            12'h004, 12'h006, 12'h008, 12'h00A, 12'h00C, 12'h00E, 12'h010,
            12'h012, 12'h024, 12'h02A, 12'h030, 12'h032, 12'h054: ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        // 0x024 and 0x030 are read-only registers.
        if (wr && ((addr == 12'h024) || (addr == 12'h030))) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    assign w_head_legal = f_addr_legal(w_head_addr, w_head_write);
`else
    assign w_head_legal = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cmd_addr  <= '0;
            r_cmd_write <= 1'b0;
            r_cmd_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_cmd_write <= w_cmd_write_nxt;
            r_cmd_wdata <= w_cmd_wdata_nxt;
        end
    end

    // The counter is held at zero outside ACCESS, so it starts from zero on
    // every entry. It counts ACCESS cycles already spent without acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != c_ST_ACCESS) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    assign w_timeout = (r_to_cnt >= c_TO_LAST);

    // ------------------------------------------------------------------------
    // FSM: next state and transition data
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_cmd_write_nxt = r_cmd_write;
        w_cmd_wdata_nxt = r_cmd_wdata;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pop) begin
                    w_cmd_addr_nxt  = w_head_addr;
                    w_cmd_write_nxt = w_head_write;
                    w_cmd_wdata_nxt = w_head_wdata;
                    if (w_head_legal) begin
                        w_state_nxt = c_ST_ACCESS;
                    end else begin
                        w_state_nxt   = c_ST_RESP;
                        w_rsp_err_nxt = 1'b1;
                    end
                end
            end
            c_ST_ACCESS: begin
                // Acknowledge takes priority over a coincident timeout.
                if (acknowledge) begin
                    w_state_nxt     = c_ST_RESP;
                    w_rsp_rdata_nxt = r_cmd_write ? 32'h0 : rd_data;
                end else if (w_timeout) begin
                    w_state_nxt   = c_ST_RESP;
                    w_rsp_err_nxt = 1'b1;
                end
            end
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs, decoded from the next state and then registered so that
    // no input reaches an output without passing a flop.
    // ------------------------------------------------------------------------
    always_comb begin
        w_req_nxt         = 1'b0;
        w_wr_valid_nxt    = 1'b0;
        w_addrs_nxt       = '0;
        w_wr_data_nxt     = '0;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_error_nxt   = 1'b0;
        w_rsp_rdata_nxt_o = '0;
        w_busy_nxt        = (w_state_nxt != c_ST_IDLE) || (w_count_nxt != '0);
        case (w_state_nxt)
            c_ST_ACCESS: begin
                w_req_nxt      = 1'b1;
                w_wr_valid_nxt = w_cmd_write_nxt;
                w_addrs_nxt    = w_cmd_addr_nxt;
                w_wr_data_nxt  = w_cmd_write_nxt ? w_cmd_wdata_nxt : 32'h0;
            end
            c_ST_RESP: begin
                w_rsp_valid_nxt   = 1'b1;
                w_rsp_error_nxt   = w_rsp_err_nxt;
                w_rsp_rdata_nxt_o = w_rsp_rdata_nxt;
            end
            default: begin
                w_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_addrs     <= '0;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_req       <= w_req_nxt;
            r_wr_valid  <= w_wr_valid_nxt;
            r_addrs     <= w_addrs_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt_o;
            r_busy      <= w_busy_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign req       = r_req;
    assign wr_valid  = r_wr_valid;
    assign addrs     = r_addrs;
    assign wr_data   = r_wr_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_error = r_rsp_error;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;

endmodule
`default_nettype wire
